vebpf_prog_loader: RTL and testbench

//  Upstream feeder of the per-function instruction store. Parses a 32-bit program stream, one packet per function:

---
 rtl/vebpf_prog_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_vebpf_prog_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vebpf_prog_loader.sv
// ---------------------------------------------------------------------------
// vebpf_prog_loader
//
// Parses a 32-bit program stream (one packet per function) and feeds the
// per-function instruction store and its pointer table.
//
// Packet layout:
//   W0 = {8'hEB, fid[7:0], N[15:0]}   N instruction words
//   W1 = {26'b0, P[5:0]}              P pointer words
//   P pointer words  (slots 0..P-1)
//   N instruction words (addresses 0..N-1)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_tdata/s_tvalid/
//   s_tready/s_tlast         program stream (AXI-stream style)
//   function_ida             target bank id, held for the whole packet
//   wea/addra/dina           instruction store write port A
//   ptr_w/ptr_addr/ptr_data  pointer-table write port
//   busy                     packet in progress
//   done                     1-cycle pulse, packet loaded
//   err/err_code             1-cycle pulse, packet rejected
//                            (1 bad header, 2 short, 3 long)
//
// State table
//   state  | meaning
//   S_IDLE | waiting for W0 of the next packet
//   S_HDR1 | W0 accepted, waiting for W1 (pointer count)
//   S_PTR  | accepting pointer-table words
//   S_INS  | accepting instruction words
//   S_FIN  | one cycle, done pulse
//   S_DROP | packet rejected, discarding beats until tlast
//   S_ERR  | one cycle, err pulse with err_code
// ---------------------------------------------------------------------------
module vebpf_prog_loader #(
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_WIDTH        = 32,
    parameter int FUNCTION_ID_WIDTH = 8,
    parameter int F_COUNT           = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    output logic [FUNCTION_ID_WIDTH-1:0] function_ida,
    output logic                         wea,
    output logic [ADDR_WIDTH-1:0]        addra,
    output logic [DATA_WIDTH-1:0]        dina,
    output logic                         ptr_w,
    output logic [4:0]                   ptr_addr,
    output logic [DATA_WIDTH-1:0]        ptr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_PTR,
        S_INS,
        S_FIN,
        S_DROP,
        S_ERR
    } state_t;

    localparam logic [1:0]  ERR_HDR   = 2'd1;
    localparam logic [1:0]  ERR_SHORT = 2'd2;
    localparam logic [1:0]  ERR_LONG  = 2'd3;
    localparam logic [31:0] MAX_N     = 32'd1 << ADDR_WIDTH;
    localparam logic [31:0] F_LIMIT   = 32'(F_COUNT);

    state_t state;
    state_t state_next;

    logic [15:0]           n_last;
    logic [5:0]            p_last;
    logic [ADDR_WIDTH-1:0] ins_cnt;
    logic [5:0]            ptr_cnt;
    logic [1:0]            pend_code;

    logic                  ins_we;
    logic                  ptr_we;
    logic                  hdr_load;
    logic                  p_load;
    logic [1:0]            code_next;

    logic [7:0]            hdr_magic;
    logic [7:0]            hdr_fid;
    logic [15:0]           hdr_n;
    logic [5:0]            hdr_p;
    logic                  w0_bad;
    logic                  w1_bad;
    logic                  beat;
    logic                  ins_last;

    assign hdr_magic = s_tdata[31:24];
    assign hdr_fid   = s_tdata[23:16];
    assign hdr_n     = s_tdata[15:0];
    assign hdr_p     = s_tdata[5:0];

    assign w0_bad = (hdr_magic != 8'hEB)
                 || ({24'd0, hdr_fid} >= F_LIMIT)
                 || (hdr_n == 16'd0)
                 || ({16'd0, hdr_n} > MAX_N);
    assign w1_bad = (hdr_p > 6'd32);

    // Ready is a pure decode of the state register, forced low while reset
    // is held so no beat can slip in during reset.
    assign s_tready = !rst && (state == S_IDLE || state == S_HDR1 ||
                               state == S_PTR  || state == S_INS  ||
                               state == S_DROP);

    assign beat     = s_tvalid && s_tready;
    assign ins_last = (16'(ins_cnt) == n_last);

    always_comb begin
        state_next = state;
        ins_we     = 1'b0;
        ptr_we     = 1'b0;
        hdr_load   = 1'b0;
        p_load     = 1'b0;
        code_next  = pend_code;
        unique case (state)
            S_IDLE: begin
                if (beat) begin
                    if (w0_bad) begin
                        code_next  = ERR_HDR;
                        state_next = s_tlast ? S_ERR : S_DROP;
                    end else begin
                        hdr_load   = 1'b1;
                        code_next  = ERR_SHORT;
                        state_next = s_tlast ? S_ERR : S_HDR1;
                    end
                end
            end
            S_HDR1: begin
                if (beat) begin
                    if (w1_bad) begin
                        code_next  = ERR_HDR;
                        state_next = s_tlast ? S_ERR : S_DROP;
                    end else if (s_tlast) begin
                        code_next  = ERR_SHORT;
                        state_next = S_ERR;
                    end else begin
                        p_load     = 1'b1;
                        state_next = (hdr_p != 6'd0) ? S_PTR : S_INS;
                    end
                end
            end
            S_PTR: begin
                if (beat) begin
                    ptr_we = 1'b1;
                    if (s_tlast) begin
                        // at least one instruction word is always still owed
                        code_next  = ERR_SHORT;
                        state_next = S_ERR;
                    end else if (ptr_cnt == p_last) begin
                        state_next = S_INS;
                    end
                end
            end
            S_INS: begin
                if (beat) begin
                    ins_we = 1'b1;
                    if (ins_last) begin
                        if (s_tlast) begin
                            state_next = S_FIN;
                        end else begin
                            code_next  = ERR_LONG;
                            state_next = S_DROP;
                        end
                    end else if (s_tlast) begin
                        code_next  = ERR_SHORT;
                        state_next = S_ERR;
                    end
                end
            end
            S_DROP: begin
                if (beat && s_tlast) begin
                    state_next = S_ERR;
                end
            end
            S_FIN:   state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            n_last       <= '0;
            p_last       <= '0;
            ins_cnt      <= '0;
            ptr_cnt      <= '0;
            pend_code    <= '0;
            function_ida <= '0;
            wea          <= 1'b0;
            addra        <= '0;
            dina         <= '0;
            ptr_w        <= 1'b0;
            ptr_addr     <= '0;
            ptr_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            state <= state_next;
            wea   <= ins_we;
            ptr_w <= ptr_we;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_FIN);
            err   <= (state_next == S_ERR);

            if (state_next == S_ERR) begin
                err_code <= code_next;
            end
            // remembered while beats are discarded, reported on the way out
            if (state_next == S_DROP) begin
                pend_code <= code_next;
            end

            // function_ida only moves on a W0 accept, which happens in IDLE,
            // so the store's late sample of the previous packet's last write
            // still sees the old id.
            if (hdr_load) begin
                function_ida <= FUNCTION_ID_WIDTH'(hdr_fid);
                n_last       <= hdr_n - 16'd1;
                ins_cnt      <= '0;
                ptr_cnt      <= '0;
                addra        <= '0;
                ptr_addr     <= '0;
            end
            if (p_load) begin
                p_last <= hdr_p - 6'd1;
            end
            if (ptr_we) begin
                ptr_addr <= ptr_cnt[4:0];
                ptr_data <= s_tdata;
                ptr_cnt  <= ptr_cnt + 6'd1;
            end
            if (ins_we) begin
                addra   <= ins_cnt;
                dina    <= s_tdata;
                ins_cnt <= ins_cnt + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vebpf_prog_loader.sv
`timescale 1ns/1ps
module tb_vebpf_prog_loader;

    localparam int AW   = 10;
    localparam int FC   = 9;
    localparam int MAXW = 1100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  function_ida;
    logic        wea;
    logic [AW-1:0] addra;
    logic [31:0] dina;
    logic        ptr_w;
    logic [4:0]  ptr_addr;
    logic [31:0] ptr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    vebpf_prog_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .FUNCTION_ID_WIDTH(8), .F_COUNT(FC)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .function_ida(function_ida), .wea(wea), .addra(addra), .dina(dina),
        .ptr_w(ptr_w), .ptr_addr(ptr_addr), .ptr_data(ptr_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ins;
        int          addr;
        logic [31:0] data;
        int          tag;
        logic [7:0]  fid;
    } wr_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          both_hi = 0;
    int          busy_cnt = 0;
    logic [1:0]  code_seen = 2'd0;
    logic [31:0] pkt [0:MAXW-1];
    int          acc_cyc [0:MAXW-1];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  last_code = 2'd0;

    // observer: everything sampled mid-cycle
    always @(negedge clk) begin
        if (wea)
            got_q.push_back('{ins: 1'b1, addr: int'(addra), data: dina, tag: cyc, fid: function_ida});
        if (ptr_w)
            got_q.push_back('{ins: 1'b0, addr: int'(ptr_addr), data: ptr_data, tag: cyc, fid: function_ida});
        if (wea && ptr_w) both_hi <= both_hi + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err) begin
            err_cnt   <= err_cnt + 1;
            code_seen <= err_code;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [7:0] magic, input logic [7:0] fid, input int n,
                         input int p, input int extra, output int len);
        pkt[0] = {magic, fid, 16'(n)};
        pkt[1] = {26'd0, 6'(p)};
        len = 2 + p + n + extra;
        for (int i = 2; i < len && i < MAXW; i++) pkt[i] = $urandom;
    endtask

    // Reference: what a len-beat packet (tlast on the last beat) must produce.
    // outcome 0 = done, else the expected err_code.
    task automatic model(input int len, output int outcome);
        logic [31:0] w0;
        int n, p, total, lim;
        wr_t e;
        exp_q.delete();
        w0 = pkt[0];
        n  = int'(w0[15:0]);
        p  = int'(pkt[1] & 32'h3f);
        if (w0[31:24] != 8'hEB || int'(w0[23:16]) >= FC || n == 0 || n > (1 << AW)) begin
            outcome = 1;
            return;
        end
        if (len < 2) begin
            outcome = 2;
            return;
        end
        if (p > 32) begin
            outcome = 1;
            return;
        end
        total = 2 + p + n;
        lim = (len < total) ? len : total;
        for (int b = 2; b < lim; b++) begin
            e.ins  = (b >= 2 + p);
            e.addr = e.ins ? b - 2 - p : b - 2;
            e.data = pkt[b];
            e.tag  = b;
            e.fid  = w0[23:16];
            exp_q.push_back(e);
        end
        if (len < total)       outcome = 2;
        else if (len == total) outcome = 0;
        else                   outcome = 3;
    endtask

    task automatic send(input int len, input bit with_last, input int gapmax);
        int g, t;
        for (int i = 0; i < len; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = pkt[i];
            s_tlast  = with_last && (i == len - 1);
            t = 0;
            while (!s_tready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_tready) begin
                check("tready_timeout", 64'(s_tready), 64'd1);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            acc_cyc[i] = cyc + 1;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_pkt(input string name, input int len, input int gapmax);
        int outcome, g0, d0, e0, bh0, bs0, nchk;
        wr_t gw, ew;
        model(len, outcome);
        g0 = got_q.size(); d0 = done_cnt; e0 = err_cnt; bh0 = both_hi; bs0 = busy_cnt;
        send(len, 1'b1, gapmax);
        repeat (6) @(negedge clk);
        check({name, "_nwr"}, 64'(got_q.size() - g0), 64'(exp_q.size()));
        nchk = (got_q.size() - g0 < exp_q.size()) ? got_q.size() - g0 : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            gw = got_q[g0 + i];
            ew = exp_q[i];
            check($sformatf("%s_kind%0d", name, i), 64'(gw.ins), 64'(ew.ins));
            check($sformatf("%s_addr%0d", name, i), 64'(gw.addr), 64'(ew.addr));
            check($sformatf("%s_data%0d", name, i), 64'(gw.data), 64'(ew.data));
            check($sformatf("%s_lat%0d", name, i), 64'(gw.tag), 64'(acc_cyc[ew.tag] + 1 - 1));
            check($sformatf("%s_fid%0d", name, i), 64'(gw.fid), 64'(ew.fid));
        end
        check({name, "_done"}, 64'(done_cnt - d0), (outcome == 0) ? 64'd1 : 64'd0);
        check({name, "_err"}, 64'(err_cnt - e0), (outcome != 0) ? 64'd1 : 64'd0);
        if (outcome != 0) last_code = 2'(outcome);
        check({name, "_code"}, 64'(err_code), 64'(last_code));
        if (outcome != 0) check({name, "_code_pulse"}, 64'(code_seen), 64'(outcome));
        check({name, "_both"}, 64'(both_hi - bh0), 64'd0);
        check({name, "_busy_len"}, 64'(busy_cnt - bs0), 64'(acc_cyc[len-1] - acc_cyc[0] + 1));
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, outcome, g0, d0, e0, total, mode;
        logic [7:0] rfid;
        int rp, rn;

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wea", 64'(wea), 64'd0);
        check("rst_ptr_w", 64'(ptr_w), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_fid", 64'(function_ida), 64'd0);
        check("rst_addra", 64'(addra), 64'd0);
        check("rst_ptr_addr", 64'(ptr_addr), 64'd0);
        check("rst_ready_idle", 64'(s_tready), 64'd1);

        build(8'hEB, 8'd3, 4, 2, 0, len);
        run_pkt("clean", len, 0);
        check("clean_fid_hold", 64'(function_ida), 64'd3);

        run_pkt("clean_gaps", len, 3);

        build(8'hEA, 8'd3, 4, 2, 0, len);
        run_pkt("bad_magic", 4, 0);

        build(8'hEB, 8'd9, 2, 1, 0, len);
        run_pkt("fid9", len, 0);
        build(8'hEB, 8'd8, 2, 1, 0, len);
        run_pkt("fid8", len, 1);

        build(8'hEB, 8'd1, 4, 0, 0, len);
        run_pkt("short", 5, 0);

        build(8'hEB, 8'd2, 2, 1, 2, len);
        run_pkt("long", len, 2);

        build(8'hEB, 8'd2, 1025, 0, 0, len);
        run_pkt("n_over", 3, 0);
        build(8'hEB, 8'd2, 0, 0, 0, len);
        run_pkt("n_zero", 3, 0);
        build(8'hEB, 8'd2, 1, 33, 0, len);
        run_pkt("p33", 3, 0);
        build(8'hEB, 8'd4, 1, 32, 0, len);
        run_pkt("p32", len, 0);
        build(8'hEA, 8'd0, 1, 0, 0, len);
        run_pkt("bad_w0_last", 1, 0);
        build(8'hEB, 8'd7, 1024, 0, 0, len);
        run_pkt("n1024", len, 0);

        // reset in the middle of the instruction words
        build(8'hEB, 8'd5, 6, 1, 0, len);
        model(5, outcome);
        g0 = got_q.size(); d0 = done_cnt; e0 = err_cnt;
        send(5, 1'b0, 0);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_ready", 64'(s_tready), 64'd0);
        check("mid_rst_fid", 64'(function_ida), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        last_code = 2'd0;
        repeat (3) @(negedge clk);
        check("mid_nwr", 64'(got_q.size() - g0), 64'(exp_q.size()));
        check("mid_done", 64'(done_cnt - d0), 64'd0);
        check("mid_err", 64'(err_cnt - e0), 64'd0);
        build(8'hEB, 8'd0, 3, 1, 0, len);
        run_pkt("after_rst", len, 0);

        for (int k = 0; k < 8; k++) begin
            rfid = 8'($urandom_range(FC - 1, 0));
            rp   = int'($urandom_range(4, 0));
            rn   = int'($urandom_range(8, 1));
            mode = int'($urandom_range(2, 0));
            build(8'hEB, rfid, rn, rp, (mode == 2) ? int'($urandom_range(3, 1)) : 0, len);
            total = 2 + rp + rn;
            if (mode == 1) len = int'($urandom_range(total - 1, 1));
            run_pkt($sformatf("rnd%0d", k), len, 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
